pipeline_stage_reg: RTL
=======================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL provide parameter CTRL_W, default 20, width of the control field zeroed on bubble/flush.
REQ-002 SHALL provide parameter DATA_W, default 192 (6 x `XLEN), width of the datapath payload retained on flush.
REQ-003 SHALL provide port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port i_flush  input  1  synchronous flush of the stage (branch/jump redirect).
REQ-006 SHALL provide port i_valid  input  1  upstream beat valid.
REQ-007 SHALL provide port o_ready  output  1  stage can accept a beat.
REQ-008 SHALL provide port i_ctrl  input  CTRL_W  upstream control bits.
REQ-009 SHALL provide port i_data  input  DATA_W  upstream payload.
REQ-010 SHALL provide port o_valid  output  1  downstream beat valid.
REQ-011 SHALL provide port i_ready  input  1  downstream accepts beat.
REQ-012 SHALL provide port o_ctrl  output  CTRL_W  registered control bits.
REQ-013 SHALL provide port o_data  output  DATA_W  registered payload.
REQ-014 SHALL provide port o_stall_cnt  output  16  count of downstream-stall cycles.

Function
REQ-015 An upstream transfer SHALL occur in a cycle with i_valid=1 and o_ready=1; a downstream transfer SHALL occur in a cycle with o_valid=1 and i_ready=1.
REQ-016 Latency SHALL be one cycle: a beat accepted into an empty stage SHALL appear on o_valid/o_ctrl/o_data the next cycle.
REQ-017 Beats SHALL leave in acceptance order, none dropped or duplicated, except by flush.
REQ-018 o_ctrl SHALL be all-zero in every cycle o_valid=0, so downstream write enables are inert in bubbles.
REQ-019 When o_valid=1 and i_ready=0, o_valid, o_ctrl and o_data SHALL hold unchanged.
REQ-020 i_flush=1 SHALL override all other inputs: next cycle o_valid=0, o_ctrl=0, all buffered beats discarded, and the beat offered in the flush cycle discarded even if o_ready=1.
REQ-021 Flush SHALL leave o_data (and skid payload) unchanged, to save toggling.
REQ-022 o_stall_cnt SHALL increment by 1 on each cycle with o_valid=1 and i_ready=0, saturate at 16'hFFFF, and be cleared only by reset; flush SHALL not clear it.
REQ-023 With simultaneous upstream and downstream transfers on a full main register, the new beat SHALL replace the departing one with no bubble.

Reset
REQ-024 While i_rst=1, asynchronously: o_valid=0, o_ctrl=0, o_data=0, skid entry empty with payload 0, o_stall_cnt=0.
REQ-025 o_ready SHALL be 1 in the first cycle after i_rst deasserts; reset asserted mid-transfer SHALL discard all beats.

Configuration
REQ-026 Macro PIPE_SKID_EN SHALL select buffering.
REQ-027 With PIPE_SKID_EN defined: a one-entry skid register SHALL be present, o_ready SHALL be a flop output equal to "skid empty", a beat accepted while main is full and i_ready=0 SHALL enter the skid, and on the next downstream transfer the skid beat SHALL move to main; full throughput SHALL be sustained.
REQ-028 Without PIPE_SKID_EN: single register only, o_ready = ~o_valid | i_ready (combinational), no skid state.

Structure
REQ-029 Shared package SHALL hold default CTRL_W/DATA_W constants and the stall-counter width (16); `XLEN comes from the common config include.
REQ-030 Sub-module pipe_sat_counter (saturating up-counter, parametrised width) SHALL implement o_stall_cnt; the data path SHALL stay in pipeline_stage_reg.

Verification
REQ-031 Streaming: i_valid=1, i_ready=1, i_data=1,2,3,4 on consecutive cycles -> o_data=1,2,3,4 one cycle later, o_valid continuous, o_stall_cnt=0.
REQ-032 Stall (PIPE_SKID_EN): load beats A=0x11, B=0x22, then i_ready=0 for 3 cycles -> o_data holds 0x11, o_ready=0 after B skids, o_stall_cnt=3; release -> 0x11 then 0x22, no loss.
REQ-033 Stall (no macro): i_ready=0 with o_valid=1 -> o_ready=0 same cycle; i_ready=1 with i_valid=1 -> new beat next cycle without bubble.
REQ-034 Flush: stage full with i_ctrl=20'hFFFFF, skid full, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_data unchanged, neither buffered beat nor the flush-cycle beat ever appears.
REQ-035 Saturation: force 70000 stall cycles -> o_stall_cnt=16'hFFFF, no wrap; flush -> still 16'hFFFF.
REQ-036 Reset mid-stream: assert i_rst asynchronously between clock edges with beats buffered -> outputs zero immediately, o_ready=1 in first cycle after release.

Source files
------------

// File: rtl/pipeline_stage_reg_pkg.sv
// pipeline_stage_reg_pkg: shared widths for the pipeline stage register.
// Provides the default control/payload widths and the stall-counter width.
// XLEN normally comes from the common config include; a 32-bit fallback keeps
// this slice self-contained.
`ifndef XLEN
`define XLEN 32
`endif

package pipeline_stage_reg_pkg;
    localparam int CTRL_W_DEF  = 20;
    localparam int DATA_W_DEF  = 6 * `XLEN;
    localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with async active-high reset.
// Ports: i_clk clock, i_rst async reset, i_inc count enable, o_cnt count value.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = (i_inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign o_cnt = cnt_q;
endmodule

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: one-cycle valid/ready pipeline register with flush and stall counter.
// Ports: i_clk, i_rst (async, active-high), i_flush (sync discard of all beats),
//        i_valid/o_ready/i_ctrl/i_data upstream, o_valid/i_ready/o_ctrl/o_data
//        downstream, o_stall_cnt saturating count of downstream-stall cycles.
// Macro PIPE_SKID_EN adds a one-entry skid buffer so o_ready is a flop output;
// without it o_ready = ~o_valid | i_ready.
module pipeline_stage_reg
    import pipeline_stage_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [CTRL_W-1:0]      i_ctrl,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [CTRL_W-1:0]      o_ctrl,
    output logic [DATA_W-1:0]      o_data,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              in_xfer, main_free;

    // Main register can take a new beat when empty or when its beat leaves now.
    assign main_free = ~valid_q | i_ready;
    assign in_xfer   = i_valid & o_ready;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    assign o_ready = ~skid_valid_q;

    // The skid only fills while main is stalled, so it is never valid with main empty.
    // Flush clears valids and ctrl but leaves payloads untouched to save toggling.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                data_d       = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                valid_d = 1'b1;
                ctrl_d  = i_ctrl;
                data_d  = i_data;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = i_ctrl;
            skid_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
`else
    assign o_ready = main_free;

    // Flush clears valid and ctrl but leaves the payload untouched to save toggling.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (i_flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            ctrl_d  = i_ctrl;
            data_d  = i_data;
        end else if (main_free) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end

    assign o_valid = valid_q;
    assign o_ctrl  = ctrl_q;
    assign o_data  = data_q;

    pipe_sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (valid_q & ~i_ready),
        .o_cnt (o_stall_cnt)
    );
endmodule
